// File: rtl/alu_arbiter_if.sv
// Handshake and ALU-side bundle between two requesters, the arbiter and the shared ALU.
// The arbiter connects through the slave modport and the requester/ALU side through the master modport.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [OPW-1:0]   req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [OPW-1:0]   req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_zero;
    logic [OPW-1:0]   alu_control;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [WIDTH-1:0] alu_result;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp0_ready, resp1_ready, alu_result,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_data, resp_zero, alu_control, alu_in1, alu_in2
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp0_ready, resp1_ready, alu_result,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_data, resp_zero, alu_control, alu_in1, alu_in2
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one operation in flight.
// Each transaction walks IDLE -> EXEC -> RESP; operands and result are both registered.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic          clock,
    input  logic          reset,
    alu_arbiter_if.slave  bus,
    output logic          busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             prio_reg;
    logic             owner_reg;
    logic [OPW-1:0]   op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] data_reg;
    logic             zero_reg;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       resp_ready;
    logic [1:0]       resp_valid;
    logic [OPW-1:0]   req_op [2];
    logic [WIDTH-1:0] req_a  [2];
    logic [WIDTH-1:0] req_b  [2];
    logic             grant;
    logic             accept;
    logic             complete;

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign resp_ready = {bus.resp1_ready, bus.resp0_ready};
    assign req_op[0]  = bus.req0_op;
    assign req_op[1]  = bus.req1_op;
    assign req_a[0]   = bus.req0_a;
    assign req_a[1]   = bus.req1_a;
    assign req_b[0]   = bus.req0_b;
    assign req_b[1]   = bus.req1_b;

    // A lone requester always wins; a tie goes to whoever holds priority.
    assign grant = req_valid[1] && (!req_valid[0] || prio_reg);

    // Ready is held low while reset is asserted so nothing appears accepted during reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            assign req_ready[gi]  = (state_reg == IDLE) && !reset && req_valid[gi] &&
                                    (grant == 1'(gi));
            assign resp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign accept   = |req_ready;
    assign complete = (state_reg == RESP) && resp_ready[owner_reg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            owner_reg <= 1'b0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            data_reg  <= '0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && accept) begin
                op_reg    <= req_op[grant];
                a_reg     <= req_a[grant];
                b_reg     <= req_b[grant];
                owner_reg <= grant;
            end
            if (state_reg == EXEC) begin
                data_reg <= bus.alu_result;
                zero_reg <= (bus.alu_result == '0);
            end
            // Priority only moves when a response is actually taken.
            if (complete) begin
                prio_reg <= ~owner_reg;
            end
        end
    end

    assign bus.req0_ready  = req_ready[0];
    assign bus.req1_ready  = req_ready[1];
    assign bus.resp0_valid = resp_valid[0];
    assign bus.resp1_valid = resp_valid[1];
    assign bus.resp_data   = data_reg;
    assign bus.resp_zero   = zero_reg;
    assign bus.alu_control = op_reg;
    assign bus.alu_in1     = a_reg;
    assign bus.alu_in2     = b_reg;
    assign busy            = (state_reg != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table vectors, hand sequences for stalls/reset/fairness,
// and a randomized run against a transaction-level reference model.
module tb_alu_arbiter;
    logic clock;
    logic reset;
    logic busy;

    alu_arbiter_if #(.WIDTH(32), .OPW(4)) bus ();

    alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // The shared ALU itself lives in the bench.
    always_comb bus.alu_result = alu_ref(bus.alu_control, bus.alu_in1, bus.alu_in2);

    wire [1:0] rdy = {bus.req1_ready, bus.req0_ready};
    wire [1:0] rv  = {bus.resp1_valid, bus.resp0_valid};

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
    endtask

    task automatic set_req(input bit n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!n) begin
            bus.req0_valid = 1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Leaves the bench just after a falling edge with reset released and the DUT in IDLE.
    task automatic do_reset();
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    typedef struct {
        bit          sel;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        bit          exp_z;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        logic [1:0] own;
        own = v.sel ? 2'b10 : 2'b01;
        @(negedge clock);
        set_req(v.sel, v.op, v.a, v.b);
        #1;
        chk($sformatf("vec%0d ready", idx), 32'(rdy), 32'(own));
        @(negedge clock);
        bus.req0_valid = 0; bus.req1_valid = 0;
        #1;
        chk($sformatf("vec%0d exec_valid", idx), 32'(rv), 32'd0);
        @(negedge clock);
        chk($sformatf("vec%0d resp_valid", idx), 32'(rv), 32'(own));
        chk($sformatf("vec%0d data", idx), bus.resp_data, v.exp_d);
        chk($sformatf("vec%0d zero", idx), 32'(bus.resp_zero), 32'(v.exp_z));
        $display("vec%0d: req%0d op=%b a=%h b=%h -> data=%h zero=%0d", idx, v.sel, v.op, v.a, v.b,
                 bus.resp_data, bus.resp_zero);
    endtask

    logic [3:0] ops_tbl[7];

    initial begin
        vecs[0] = '{0, 4'b0010, 32'd5,        32'd7,        32'd12,         0};
        vecs[1] = '{1, 4'b1111, 32'd3,        32'd4,        32'd0,          1};
        vecs[2] = '{1, 4'b0111, 32'd2,        32'd3,        32'd1,          0};
        vecs[3] = '{0, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,          0};
        vecs[4] = '{0, 4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE,   0};
        vecs[5] = '{1, 4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 0};
        vecs[6] = '{0, 4'b1100, 32'h0000_00FF, 32'hFF00_0000, 32'h00FF_FF00, 0};
        vecs[7] = '{1, 4'b0111, 32'd3,        32'd2,        32'd0,          1};
        ops_tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111};

        idle_inputs();
        reset = 1;
        bus.req0_valid = 1;
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("reset ready", 32'(rdy), 32'd0);
        chk("reset resp_valid", 32'(rv), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset data", bus.resp_data, 32'd0);
        chk("reset zero", 32'(bus.resp_zero), 32'd0);
        chk("reset alu_control", 32'(bus.alu_control), 32'd0);
        chk("reset alu_in1", bus.alu_in1, 32'd0);
        chk("reset alu_in2", bus.alu_in2, 32'd0);
        bus.req0_valid = 0;
        @(negedge clock);
        reset = 0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Simultaneous requests straight after reset: requester 0 first.
        do_reset();
        set_req(0, 4'b0110, 32'd9, 32'd9);
        set_req(1, 4'b0001, 32'hF0, 32'h0F);
        #1;
        chk("tie ready", 32'(rdy), 32'b01);
        @(negedge clock);
        bus.req0_valid = 0;
        #1;
        chk("tie exec ready", 32'(rdy), 32'd0);
        @(negedge clock);
        chk("tie resp0 valid", 32'(rv), 32'b01);
        chk("tie resp0 data", bus.resp_data, 32'd0);
        chk("tie resp0 zero", 32'(bus.resp_zero), 32'd1);
        @(negedge clock);
        #1;
        chk("tie second ready", 32'(rdy), 32'b10);
        @(negedge clock);
        bus.req1_valid = 0;
        @(negedge clock);
        chk("tie resp1 valid", 32'(rv), 32'b10);
        chk("tie resp1 data", bus.resp_data, 32'hFF);
        $display("tie: req0 then req1 served, data=%h", bus.resp_data);

        // Response back-pressure for 5 cycles while requester 1 waits.
        @(negedge clock);
        bus.resp0_ready = 0;
        set_req(0, 4'b0010, 32'd1, 32'd1);
        #1;
        chk("stall accept", 32'(rdy), 32'b01);
        @(negedge clock);
        bus.req0_valid = 0;
        set_req(1, 4'b0000, 32'hFF, 32'h0F);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            chk($sformatf("stall%0d resp_valid", i), 32'(rv), 32'b01);
            chk($sformatf("stall%0d data", i), bus.resp_data, 32'd2);
            chk($sformatf("stall%0d req1 ready", i), 32'(rdy), 32'd0);
        end
        bus.resp0_ready = 1;
        @(negedge clock);
        #1;
        chk("stall release ready", 32'(rdy), 32'b10);
        @(negedge clock);
        bus.req1_valid = 0;
        @(negedge clock);
        chk("stall resp1 data", bus.resp_data, 32'h0F);
        $display("stall: held 5 cycles, req1 then served data=%h", bus.resp_data);

        // Reset while in RESP: req0 completes first so prio moves to 1, then req1 is dropped.
        run_vec(vecs[0], 100);
        @(negedge clock);
        bus.resp1_ready = 0;
        set_req(1, 4'b0010, 32'd3, 32'd4);
        @(negedge clock);
        bus.req1_valid = 0;
        @(negedge clock);
        chk("rst mid resp_valid before", 32'(rv), 32'b10);
        #2;
        reset = 1;
        #1;
        chk("rst mid resp_valid", 32'(rv), 32'd0);
        chk("rst mid data", bus.resp_data, 32'd0);
        chk("rst mid busy", 32'(busy), 32'd0);
        chk("rst mid alu_in1", bus.alu_in1, 32'd0);
        @(negedge clock);
        reset = 0;
        bus.resp1_ready = 1;
        set_req(0, 4'b0010, 32'd20, 32'd22);
        set_req(1, 4'b0110, 32'd20, 32'd22);
        #1;
        chk("rst mid prio", 32'(rdy), 32'b01);
        @(negedge clock);
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge clock);
        chk("rst mid next data", bus.resp_data, 32'd42);
        $display("reset-in-RESP: dropped, next op data=%h", bus.resp_data);

        // Continuous contention: grants alternate, one op per 3 cycles.
        do_reset();
        set_req(0, 4'b0010, 32'd10, 32'd1);
        set_req(1, 4'b0110, 32'd10, 32'd1);
        for (int c = 0; c < 18; c++) begin
            if (c > 0) @(negedge clock);
            #1;
            if (c % 3 == 0) begin
                chk($sformatf("rr c%0d grant", c), 32'(rdy), ((c / 3) % 2 == 0) ? 32'b01 : 32'b10);
                $display("rr: cycle %0d grant=%b", c, rdy);
            end else begin
                chk($sformatf("rr c%0d ready", c), 32'(rdy), 32'd0);
            end
            if (c % 3 == 2)
                chk($sformatf("rr c%0d data", c), bus.resp_data, ((c / 3) % 2 == 0) ? 32'd11 : 32'd9);
        end

        // Randomized run against the transaction-level model.
        idle_inputs();
        do_reset();
        begin
            bit          m_busy = 0;
            bit          m_prio = 0;
            bit          m_owner = 0;
            int          m_vis = 0;
            logic [31:0] m_res = 0;
            logic [1:0]  exp_rdy, exp_rv;
            for (int cyc = 0; cyc < 400; cyc++) begin
                if (cyc > 0) @(negedge clock);
                bus.req0_valid = ($urandom_range(0, 1) == 1);
                bus.req1_valid = ($urandom_range(0, 1) == 1);
                bus.req0_op = ops_tbl[$urandom_range(0, 6)];
                bus.req1_op = ops_tbl[$urandom_range(0, 6)];
                bus.req0_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                bus.req0_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                bus.req1_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                bus.req1_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                bus.resp0_ready = ($urandom_range(0, 3) != 0);
                bus.resp1_ready = ($urandom_range(0, 3) != 0);
                #1;
                exp_rdy = 2'b00;
                exp_rv  = 2'b00;
                if (!m_busy) begin
                    if (bus.req0_valid && (!bus.req1_valid || !m_prio)) exp_rdy = 2'b01;
                    else if (bus.req1_valid) exp_rdy = 2'b10;
                end else if (cyc >= m_vis) begin
                    exp_rv = m_owner ? 2'b10 : 2'b01;
                end
                chk($sformatf("rand c%0d ready", cyc), 32'(rdy), 32'(exp_rdy));
                chk($sformatf("rand c%0d resp_valid", cyc), 32'(rv), 32'(exp_rv));
                chk($sformatf("rand c%0d busy", cyc), 32'(busy), 32'(m_busy));
                if (exp_rv != 2'b00) begin
                    chk($sformatf("rand c%0d data", cyc), bus.resp_data, m_res);
                    chk($sformatf("rand c%0d zero", cyc), 32'(bus.resp_zero), 32'(m_res == 32'd0));
                end
                if (exp_rdy != 2'b00) begin
                    m_busy  = 1;
                    m_owner = exp_rdy[1];
                    m_res   = m_owner ? alu_ref(bus.req1_op, bus.req1_a, bus.req1_b)
                                      : alu_ref(bus.req0_op, bus.req0_a, bus.req0_b);
                    m_vis   = cyc + 2;
                    $display("rand c%0d: accept req%0d expect %h", cyc, m_owner, m_res);
                end else if (exp_rv != 2'b00 &&
                             (m_owner ? bus.resp1_ready : bus.resp0_ready)) begin
                    m_busy = 0;
                    m_prio = ~m_owner;
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
